// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch stage of the RV32I core. Owns the program counter, issues
// word fetches to instruction memory over a request/grant interface and keeps
// returned instructions in a small FIFO whose head is offered to decode
// together with its PC. A redirect from execute flushes everything buffered,
// arranges for responses still in flight to be discarded, and restarts
// fetching at the (word-aligned) target.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2); also bounds
//               in-flight requests plus buffered entries (fetch credit)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (word aligned)
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   in-order response valid
//   imem_rdata   in   fetched instruction word
//   instr_valid  out  instr / instr_pc valid toward decode
//   instr        out  instruction at FIFO head
//   instr_pc     out  address of instr
//   instr_ready  in   decode consumes the head
//   redirect     in   flush and restart fetch
//   redirect_pc  in   restart address, bits [1:0] treated as zero
//
// Build option
//   IF_FETCH_BYPASS_EN  when defined, a live response arriving while the FIFO
//                       is empty is presented to decode in the same cycle
//                       (combinational path imem_rdata -> instr) and is not
//                       written into the FIFO if decode accepts it at once.
//                       When undefined every instruction passes through the
//                       FIFO registers (one cycle of latency).
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Architectural state
  logic [31:0]   pc_q,      pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q,   outst_d;
  logic [CW-1:0] drop_q,    drop_d;
  logic [CW-1:0] count_q,   count_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;

  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q    [FIFO_DEPTH];

  // Per-cycle events
  logic        grant;
  logic        rsp_live;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] target;
  logic [CW:0] credit_used;

  // Low address bits of the redirect target are simply masked off.
  assign target = redirect_pc & 32'hFFFF_FFFC;

  // Credit is computed from registered state only, so imem_req has no
  // combinational dependency on the memory or decode handshakes.
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req    = !rst && (credit_used < DEPTH_W);
  assign imem_addr   = pc_q;

  assign grant = imem_req && imem_gnt;

  // A response is live when nothing stale is still ahead of it. A response in
  // the redirect cycle belongs to the old stream and is always discarded.
  assign rsp_live = imem_rvalid && (drop_q == '0) && !redirect && !rst;

`ifdef IF_FETCH_BYPASS_EN
  assign bypass = rsp_live && (count_q == '0);

  always_comb begin
    if (bypass) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = resp_pc_q;
    end else begin
      instr_valid = (count_q != '0);
      instr       = fifo_instr_q[rd_ptr_q];
      instr_pc    = fifo_pc_q[rd_ptr_q];
    end
  end
`else
  assign bypass      = 1'b0;
  assign instr_valid = (count_q != '0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
`endif

  // A bypassed instruction accepted by decode in the same cycle never needs
  // a FIFO slot. Only real FIFO entries are popped.
  assign push = rsp_live && !(bypass && instr_ready);
  assign pop  = instr_ready && (count_q != '0);

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q + CW'(grant) - CW'(imem_rvalid);
    drop_d    = drop_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old
      // stream, including a request granted right now.
      pc_d      = target;
      resp_pc_d = target;
      drop_d    = outst_d;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage is cleared on reset so instr / instr_pc read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // Fetch credit makes these impossible; any hit is a design error.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == DEPTH_C)));

  a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outst_q == '0)));

  a_outst_bound : assert property (@(posedge clk) disable iff (rst)
    !(grant && (outst_q == DEPTH_C)));

endmodule
